// File: rtl/fare_calc_if.sv
// Meter-side bundle for the fare engine: trip controls and odometer in, fare status out.
interface fare_calc_if;
  logic        work;
  logic        start;
  logic [15:0] distance;
  logic [19:0] fare;
  logic [15:0] wait_time;
  logic        fare_valid;
  logic        sat;

  modport master (
    output work, start, distance,
    input  fare, wait_time, fare_valid, sat
  );

  modport slave (
    input  work, start, distance,
    output fare, wait_time, fare_valid, sat
  );
endinterface

// File: rtl/fare_calc.sv
// Taxi-meter fare engine: base fare, per-km charge past the included distance,
// waiting-time charge, saturating at the display limit and held at trip end.
module fare_calc #(
  parameter int unsigned BASE_FARE   = 800,
  parameter int unsigned BASE_DIST   = 2,
  parameter int unsigned RATE_PER_KM = 150,
  parameter int unsigned WAIT_UNIT   = 20,
  parameter int unsigned WAIT_RATE   = 50,
  parameter int unsigned FARE_MAX    = 99999
) (
  input  logic        clk,
  input  logic        reset,
  fare_calc_if.slave  bus
);
  localparam int unsigned FW = 20;
  localparam int unsigned DW = 16;
  localparam int unsigned TW = 16;
  localparam int unsigned SW = FW + 1;
  localparam int unsigned CW = (WAIT_UNIT > 1) ? $clog2(WAIT_UNIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_HOLD} state_t;

  state_t          r_state;
  logic [FW-1:0]   r_fare;
  logic [TW-1:0]   r_wait_time;
  logic            r_fare_valid;
  logic            r_sat;
  logic [CW-1:0]   r_wait_cnt;
  logic [DW-1:0]   r_dist_base;
  logic [DW-1:0]   r_dist_q;

  logic [DW-1:0]   w_trip_dist;
  logic            w_km_hit;
  logic            w_unit_hit;
  logic [SW-1:0]   w_sum;

  // Modulo-2^16 subtraction keeps trip distance correct across odometer wrap
  assign w_trip_dist = bus.distance - r_dist_base;
  assign w_km_hit    = (bus.distance != r_dist_q) && (w_trip_dist > DW'(BASE_DIST));
  assign w_unit_hit  = (r_state == S_WAIT) && (r_wait_cnt == CW'(WAIT_UNIT - 1));
  assign w_sum       = SW'(r_fare)
                     + (w_km_hit   ? SW'(RATE_PER_KM) : SW'(0))
                     + (w_unit_hit ? SW'(WAIT_RATE)   : SW'(0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_fare       <= '0;
      r_wait_time  <= '0;
      r_fare_valid <= 1'b0;
      r_sat        <= 1'b0;
      r_wait_cnt   <= '0;
      r_dist_base  <= '0;
      r_dist_q     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (bus.work) begin
            r_state      <= bus.start ? S_WAIT : S_RUN;
            r_fare       <= FW'(BASE_FARE);
            r_wait_time  <= '0;
            r_fare_valid <= 1'b0;
            r_sat        <= 1'b0;
            r_wait_cnt   <= '0;
            r_dist_base  <= bus.distance;
            r_dist_q     <= bus.distance;
          end
        end
        S_RUN, S_WAIT: begin
          // Ending the trip freezes the fare; a partial wait unit is dropped
          if (!bus.work) begin
            r_state      <= S_HOLD;
            r_fare_valid <= 1'b1;
          end else begin
            r_state  <= bus.start ? S_WAIT : S_RUN;
            r_dist_q <= bus.distance;
            if (r_state == S_WAIT)
              r_wait_cnt <= w_unit_hit ? CW'(0) : r_wait_cnt + CW'(1);
            if (w_unit_hit && (r_wait_time != {TW{1'b1}}))
              r_wait_time <= r_wait_time + TW'(1);
            if (w_sum > SW'(FARE_MAX)) begin
              r_fare <= FW'(FARE_MAX);
              r_sat  <= 1'b1;
            end else begin
              r_fare <= w_sum[FW-1:0];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.fare       = r_fare;
  assign bus.wait_time  = r_wait_time;
  assign bus.fare_valid = r_fare_valid;
  assign bus.sat        = r_sat;
endmodule

// File: tb/tb_fare_calc.sv
// Bench for fare_calc: two instances (default cap and a 1000-cent cap) share one
// stimulus and are checked every cycle against a trip-level fare model.
module tb_fare_calc;
  localparam int unsigned BASE   = 800;
  localparam int unsigned BDIST  = 2;
  localparam int unsigned RATE   = 150;
  localparam int unsigned WUNIT  = 20;
  localparam int unsigned WRATE  = 50;
  localparam int unsigned CAP_A  = 99999;
  localparam int unsigned CAP_B  = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        work = 1'b0;
  logic        start = 1'b0;
  logic [15:0] distance = 16'd0;

  int errors = 0;
  int checks = 0;

  fare_calc_if bus_a();
  fare_calc_if bus_b();

  assign bus_a.work = work;
  assign bus_a.start = start;
  assign bus_a.distance = distance;
  assign bus_b.work = work;
  assign bus_b.start = start;
  assign bus_b.distance = distance;

  fare_calc u_a (.clk(clk), .reset(reset), .bus(bus_a));
  fare_calc #(.FARE_MAX(CAP_B)) u_b (.clk(clk), .reset(reset), .bus(bus_b));

  always #5 clk = ~clk;

  // Trip model: totals of charged km and waited cycles; fare is derived from them
  bit          m_started = 1'b0;
  bit          m_active  = 1'b0;
  bit          m_waiting = 1'b0;
  bit          m_valid   = 1'b0;
  logic [15:0] m_base    = 16'd0;
  logic [15:0] m_prev    = 16'd0;
  int unsigned m_km      = 0;
  int unsigned m_wcyc    = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_started = 1'b0; m_active = 1'b0; m_waiting = 1'b0; m_valid = 1'b0;
      m_km = 0; m_wcyc = 0;
    end else if (!m_active) begin
      if (work) begin
        m_started = 1'b1; m_active = 1'b1; m_waiting = start; m_valid = 1'b0;
        m_base = distance; m_prev = distance; m_km = 0; m_wcyc = 0;
      end
    end else if (!work) begin
      m_active = 1'b0;
      m_valid  = 1'b1;
    end else begin
      if (distance != m_prev && 16'(distance - m_base) > 16'(BDIST)) m_km++;
      if (m_waiting) m_wcyc++;
      m_prev    = distance;
      m_waiting = start;
    end
  end

  function automatic int unsigned m_raw();
    return BASE + RATE * m_km + WRATE * (m_wcyc / WUNIT);
  endfunction

  function automatic int unsigned m_fare(input int unsigned cap);
    if (!m_started) return 0;
    return (m_raw() > cap) ? cap : m_raw();
  endfunction

  function automatic int unsigned m_sat(input int unsigned cap);
    return (m_started && m_raw() > cap) ? 1 : 0;
  endfunction

  function automatic int unsigned m_wait_time();
    if (!m_started) return 0;
    return (m_wcyc / WUNIT > 65535) ? 65535 : m_wcyc / WUNIT;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a_fare",  bus_a.fare,       m_fare(CAP_A));
    chk("a_wait",  bus_a.wait_time,  m_wait_time());
    chk("a_valid", bus_a.fare_valid, m_valid);
    chk("a_sat",   bus_a.sat,        m_sat(CAP_A));
    chk("b_fare",  bus_b.fare,       m_fare(CAP_B));
    chk("b_wait",  bus_b.wait_time,  m_wait_time());
    chk("b_valid", bus_b.fare_valid, m_valid);
    chk("b_sat",   bus_b.sat,        m_sat(CAP_B));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    tick(2);
    chk("lit_idle_fare", bus_a.fare, 0);

    // Trip from 0 km, one km per 10 cycles
    work = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(10);
      distance = 16'(k);
    end
    tick(10);
    chk("lit_run_fare",   bus_a.fare, 1250);
    chk("lit_model_1250", m_fare(CAP_A), 1250);
    chk("lit_cap_fare",   bus_b.fare, 1000);
    chk("lit_cap_sat",    bus_b.sat, 1);

    // Reset mid-trip abandons it
    reset = 1'b1;
    tick(1);
    chk("lit_rst_fare",  bus_a.fare, 0);
    chk("lit_rst_wait",  bus_a.wait_time, 0);
    chk("lit_rst_valid", bus_a.fare_valid, 0);
    chk("lit_rst_sat",   bus_b.sat, 0);
    tick(2);
    reset = 1'b0;
    for (int k = 6; k <= 10; k++) begin
      tick(10);
      distance = 16'(k);
    end
    tick(10);
    chk("lit_rerun_fare", bus_a.fare, 1250);

    // Waiting: 45 then 15 stopped cycles
    start = 1'b1;
    tick(45);
    start = 1'b0;
    tick(5);
    chk("lit_wait1_fare", bus_a.fare, 1350);
    chk("lit_wait1_time", bus_a.wait_time, 2);
    start = 1'b1;
    tick(15);
    start = 1'b0;
    tick(5);
    chk("lit_wait2_fare", bus_a.fare, 1400);
    chk("lit_wait2_time", bus_a.wait_time, 3);

    // Trip end holds the fare; odometer movement is ignored
    work = 1'b0;
    tick(1);
    chk("lit_hold_valid", bus_a.fare_valid, 1);
    chk("lit_hold_fare",  bus_a.fare, 1400);
    distance = distance + 16'd3;
    tick(5);
    chk("lit_hold_frozen", bus_a.fare, 1400);
    work = 1'b1;
    tick(1);
    chk("lit_new_fare",  bus_a.fare, 800);
    chk("lit_new_valid", bus_a.fare_valid, 0);
    chk("lit_new_wait",  bus_a.wait_time, 0);
    chk("lit_new_sat",   bus_b.sat, 0);

    // Trip across the odometer wrap
    work = 1'b0;
    tick(2);
    distance = 16'd65534;
    tick(2);
    work = 1'b1;
    tick(3);
    distance = 16'd65535; tick(5);
    chk("lit_wrap1", bus_a.fare, 800);
    distance = 16'd0;     tick(5);
    chk("lit_wrap2", bus_a.fare, 800);
    distance = 16'd1;     tick(5);
    chk("lit_wrap3", bus_a.fare, 950);
    distance = 16'd2;     tick(5);
    chk("lit_wrap4", bus_a.fare, 1100);

    // km step on the same edge as a completed wait unit
    start = 1'b1;
    tick(20);
    chk("lit_pre_coinc", bus_a.fare, 1100);
    distance = 16'd3;
    tick(1);
    chk("lit_coinc_fare", bus_a.fare, 1300);
    chk("lit_coinc_wait", bus_a.wait_time, 1);
    start = 1'b0;
    work  = 1'b0;
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
